text_pixel_gen: RTL
===================

Name: text_pixel_gen

Overview:
- Pixel-generation stage directly downstream of the VGA sync generator in the text controller.
- Consumes pixel_x/pixel_y/video_on/p_tick/hsync/vsync and holds an 80x30 character buffer filled through a cursor-based write port.
- Looks up glyph rows in an external 8x16 font ROM and drives pipelined RGB with hsync/vsync realigned to it.

Parameters:
- FG_COLOR, 12'hFFF, foreground RGB (4:4:4)
- BG_COLOR, 12'h000, background RGB
- CLEAR_CHAR, 7'h20, fill code used by a clear sequence

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pixel_x  in  10  horizontal pixel count
- pixel_y  in  10  vertical pixel count
- video_on  in  1  visible-area flag
- p_tick  in  1  pixel-enable strobe, one clk wide, at most every 2nd clk
- hsync_in  in  1  raw hsync
- vsync_in  in  1  raw vsync
- wr_en  in  1  write-character strobe
- wr_char  in  7  ASCII code
- busy  out  1  write port not accepting
- font_addr  out  11  {char[6:0], glyph_row[3:0]}
- font_data  in  8  glyph row, valid 1 clk after font_addr
- rgb  out  12  pixel colour
- hsync  out  1  hsync delayed to match rgb
- vsync  out  1  vsync delayed to match rgb

Behaviour:
- Reset values: rgb=0, hsync=0, vsync=0, font_addr=0, cursor=(0,0). busy=1 because reset enters CLEAR.
- Display pipeline: every pipeline register advances only on p_tick=1; it holds otherwise.
  - S1: char RAM read at addr = row*80+col, with col=pixel_x[9:3], row=pixel_y[8:4]. row*80 is computed as (row<<6)+(row<<4), giving a 12-bit address.
  - S2: font_addr = {char_q, y[3:0]} from S1 registers; font_data sampled on the next p_tick.
  - S3: bit = font_data[7 - x[2:0]]; rgb = bit ? FG_COLOR : BG_COLOR when delayed video_on=1, else 0.
- Alignment: x[2:0], y[3:0], video_on, hsync_in and vsync_in travel with the data. Total latency is exactly 3 p_ticks for rgb, hsync and vsync.
- Cells with col>=80 or row>=30 display BG_COLOR, and the RAM is not read.
- Write FSM states: CLEAR, IDLE.
  - CLEAR: writes CLEAR_CHAR to addresses 0..2399, one per clk (2400 clk). busy=1. Cursor is set to (0,0). Exits to IDLE.
  - IDLE: busy=0. On wr_en=1, the code is decoded in one clk:
  - 0x20-0x7E: write at cursor; col++. col 79 wraps to col 0, row++. row 29 wraps to row 0; there is no scroll.
  - 0x0A or 0x0D: col=0, row++ with the same wrap.
  - 0x0C: enter CLEAR.
  - Any other code: ignored, cursor unchanged.
- wr_en while busy=1 is dropped; there is no queueing.
- Char RAM is simple dual-port, so display reads and FSM writes are independent. A same-cell read/write collision returns old or new data; either is legal.
- Asynchronous reset mid-CLEAR restarts CLEAR from address 0.

Optional Feature:
- Macro: TEXT_CURSOR_BLINK_EN.
- Defined:
  - A 6-bit frame counter increments on each rising edge of vsync_in; it resets to 0.
  - While counter[5]=1, the cell at the cursor position displays inverted: FG/BG swapped, all 128 pixels.
- Undefined: the cursor is not displayed and there is no frame counter.

Decomposition:
- Package text_pkg holds:
  - TEXT_COLS=80, TEXT_ROWS=30, CHAR_W=8, CHAR_H=16
  - BUF_DEPTH=2400, BUF_AW=12
  - Control codes LF=7'h0A, FF=7'h0C, CR=7'h0D
  - Write-FSM state encoding
- One sub-module, char_ram: 2400x7 simple dual-port, with sync read (read enable = p_tick) and sync write.

Test Plan:
- Reset release: busy=1 for exactly 2400 clk, then 0. Every cell reads 0x20, so the full frame is BG_COLOR.
- Write 'A' (0x41) after clear, then scan pixel (0,0): font_addr=0x410. With font_data=8'h80, rgb=FG_COLOR exactly 3 p_ticks after pixel (0,0) and BG_COLOR at x=1.
- Sequence of 80 printable chars: cursor wraps to (0,1). Continuing through cell (79,29) returns the cursor to (0,0), and the next char overwrites addr 0.
- Write 0x0D at col 5, row 2 -> cursor (0,3). Write 0x07 -> no RAM write, cursor unchanged.
- Write 0x0C: busy=1 for 2400 clk. A wr_en pulse of 0x42 during CLEAR is dropped; after CLEAR all cells are 0x20 and the cursor is (0,0).
- hsync_in/vsync_in edges appear on hsync/vsync 3 p_ticks later. With video_on=0, rgb=0 regardless of font_data=8'hFF.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants, write-FSM encoding and cell-address helper for the
// text-mode pixel generator.
package text_pkg;

   localparam int TEXT_COLS = 80;
   localparam int TEXT_ROWS = 30;
   localparam int CHAR_W    = 8;
   localparam int CHAR_H    = 16;
   localparam int BUF_DEPTH = 2400;
   localparam int BUF_AW    = 12;

   localparam logic [6:0] LF = 7'h0A;
   localparam logic [6:0] FF = 7'h0C;
   localparam logic [6:0] CR = 7'h0D;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } wr_state_t;

   // row*80 built from two shifts so no multiplier is needed.
   function automatic logic [BUF_AW-1:0] cell_addr(input logic [4:0] row,
                                                   input logic [6:0] col);
      logic [BUF_AW-1:0] w_row;
      w_row = {7'd0, row};
      return (w_row << 6) + (w_row << 4) + {5'd0, col};
   endfunction

endpackage

// File: rtl/text_pixel_gen_char_ram.sv
// 2400x7 simple dual-port character buffer: synchronous write port for the
// write FSM, synchronous enabled read port for the display pipeline.
module char_ram
   import text_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [BUF_AW-1:0] i_waddr,
   input  logic [6:0]        i_wdata,
   input  logic              i_re,
   input  logic [BUF_AW-1:0] i_raddr,
   output logic [6:0]        o_rdata
);

   logic [6:0] r_mem [0:BUF_DEPTH-1];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (i_re) begin
         o_rdata <= r_mem[i_raddr];
      end
   end

endmodule

// File: rtl/text_pixel_gen.sv
// Text-mode pixel generator: 80x30 char buffer, font lookup, 3-stage RGB pipe.
// Optional cursor blink is enabled by defining TEXT_CURSOR_BLINK_EN.
module text_pixel_gen
   import text_pkg::*;
#(
   parameter logic [11:0] FG_COLOR   = 12'hFFF,
   parameter logic [11:0] BG_COLOR   = 12'h000,
   parameter logic [6:0]  CLEAR_CHAR = 7'h20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        p_tick,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        wr_en,
   input  logic [6:0]  wr_char,
   output logic        busy,
   output logic [10:0] font_addr,
   input  logic [7:0]  font_data,
   output logic [11:0] rgb,
   output logic        hsync,
   output logic        vsync
);

   wr_state_t         r_state;
   wr_state_t         w_state_nxt;
   logic [BUF_AW-1:0] r_clr_addr;
   logic [6:0]        r_cur_col;
   logic [4:0]        r_cur_row;
   logic [4:0]        w_row_inc;
   logic              w_printable;
   logic              w_newline;
   logic              w_is_ff;
   logic              w_clr_last;
   logic              w_we;
   logic [BUF_AW-1:0] w_waddr;
   logic [6:0]        w_wdata;

   assign w_printable = (wr_char >= 7'h20) && (wr_char <= 7'h7E);
   assign w_newline   = (wr_char == LF) || (wr_char == CR);
   assign w_is_ff     = (wr_char == FF);
   assign w_clr_last  = (r_clr_addr == BUF_AW'(BUF_DEPTH - 1));
   assign w_row_inc   = (r_cur_row == 5'(TEXT_ROWS - 1)) ? 5'd0 : r_cur_row + 5'd1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_CLEAR: if (w_clr_last) w_state_nxt = ST_IDLE;
         ST_IDLE:  if (wr_en && w_is_ff) w_state_nxt = ST_CLEAR;
         default:  w_state_nxt = ST_CLEAR;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      w_we    = 1'b0;
      w_waddr = r_clr_addr;
      w_wdata = CLEAR_CHAR;
      case (r_state)
         ST_CLEAR: begin
            busy = 1'b1;
            w_we = 1'b1;
         end
         ST_IDLE: begin
            if (wr_en && w_printable) begin
               w_we    = 1'b1;
               w_waddr = cell_addr(r_cur_row, r_cur_col);
               w_wdata = wr_char;
            end
         end
         default: busy = 1'b1;
      endcase
   end

   // Clear counter rests at 0 in IDLE so a form feed always restarts from cell 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_clr_addr <= '0;
         r_cur_col  <= '0;
         r_cur_row  <= '0;
      end else if (r_state == ST_CLEAR) begin
         r_cur_col  <= '0;
         r_cur_row  <= '0;
         r_clr_addr <= w_clr_last ? '0 : r_clr_addr + 1'b1;
      end else if (wr_en) begin
         if (w_printable) begin
            if (r_cur_col == 7'(TEXT_COLS - 1)) begin
               r_cur_col <= '0;
               r_cur_row <= w_row_inc;
            end else begin
               r_cur_col <= r_cur_col + 7'd1;
            end
         end else if (w_newline) begin
            r_cur_col <= '0;
            r_cur_row <= w_row_inc;
         end
      end
   end

   logic [6:0]        w_col;
   logic [5:0]        w_row;
   logic              w_in_range;
   logic [BUF_AW-1:0] w_raddr;
   logic [6:0]        w_rdata;

   assign w_col      = pixel_x[9:3];
   assign w_row      = pixel_y[9:4];
   assign w_in_range = (w_col < 7'(TEXT_COLS)) && (w_row < 6'(TEXT_ROWS));
   assign w_raddr    = cell_addr(w_row[4:0], w_col);

   char_ram u_char_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_wdata (w_wdata),
      .i_re    (p_tick & w_in_range),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   logic [2:0] r_s1_x;
   logic [3:0] r_s1_y;
   logic       r_s1_von, r_s1_hs, r_s1_vs, r_s1_vis, r_s1_cur;
   logic [2:0] r_s2_x;
   logic       r_s2_von, r_s2_hs, r_s2_vs, r_s2_vis, r_s2_cur;
   logic       w_cur_hit;
   logic       w_inv;
   logic       w_pix;

`ifdef TEXT_CURSOR_BLINK_EN
   logic [5:0] r_frame;
   logic       r_vs_prev;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame   <= '0;
         r_vs_prev <= 1'b0;
      end else begin
         r_vs_prev <= vsync_in;
         if (vsync_in && !r_vs_prev) begin
            r_frame <= r_frame + 6'd1;
         end
      end
   end

   assign w_cur_hit = w_in_range && (w_col == r_cur_col) && (w_row[4:0] == r_cur_row);
   assign w_inv     = r_s2_cur & r_frame[5];
`else
   assign w_cur_hit = 1'b0;
   assign w_inv     = 1'b0;
`endif

   // Out-of-range cells force the glyph bit low so they always show background.
   assign w_pix = r_s2_vis & (font_data[3'd7 - r_s2_x] ^ w_inv);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_x    <= '0;
         r_s1_y    <= '0;
         r_s1_von  <= 1'b0;
         r_s1_hs   <= 1'b0;
         r_s1_vs   <= 1'b0;
         r_s1_vis  <= 1'b0;
         r_s1_cur  <= 1'b0;
         font_addr <= '0;
         r_s2_x    <= '0;
         r_s2_von  <= 1'b0;
         r_s2_hs   <= 1'b0;
         r_s2_vs   <= 1'b0;
         r_s2_vis  <= 1'b0;
         r_s2_cur  <= 1'b0;
         rgb       <= '0;
         hsync     <= 1'b0;
         vsync     <= 1'b0;
      end else if (p_tick) begin
         r_s1_x    <= pixel_x[2:0];
         r_s1_y    <= pixel_y[3:0];
         r_s1_von  <= video_on;
         r_s1_hs   <= hsync_in;
         r_s1_vs   <= vsync_in;
         r_s1_vis  <= w_in_range;
         r_s1_cur  <= w_cur_hit;
         font_addr <= {w_rdata, r_s1_y};
         r_s2_x    <= r_s1_x;
         r_s2_von  <= r_s1_von;
         r_s2_hs   <= r_s1_hs;
         r_s2_vs   <= r_s1_vs;
         r_s2_vis  <= r_s1_vis;
         r_s2_cur  <= r_s1_cur;
         rgb       <= !r_s2_von ? 12'h000 : (w_pix ? FG_COLOR : BG_COLOR);
         hsync     <= r_s2_hs;
         vsync     <= r_s2_vs;
      end
   end

endmodule
